data_sync_tx_arbiter: RTL
=========================

# data_sync_tx_arbiter

Source-domain scheduler that shares one multi-flop data synchronizer channel between several requesters. It accepts one word at a time through valid/ready handshakes, using round-robin arbitration. It drives the synchronizer's unsynchronized bus and enable level, holding each word stable with `bus_enable` high for a programmable number of cycles, then enforces a low gap so the destination pulse generator sees one clean edge per word. It runs entirely in the source clock domain, in front of the synchronizer.

## Interface
- `BUS_WIDTH`, 8, data word width.
- `NUM_REQ`, 4, number of requesters (≥2).
- `HOLD_CYCLES`, 6, cycles `bus_enable` stays high per word (≥1). Sized ≥ destination sync stages + 2 source cycles.
- `GAP_CYCLES`, 4, cycles `bus_enable` stays low after each word (≥1).

- `CLK`  in  1  source clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*BUS_WIDTH  word of requester i at bits [i*BUS_WIDTH +: BUS_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot accept, combinational.
- `unsync_bus`  out  BUS_WIDTH  registered word to the synchronizer.
- `bus_enable`  out  1  registered enable level to the synchronizer.
- `grant_id`  out  clog2(NUM_REQ)  registered index of the last accepted requester.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, HOLD, GAP.
  - IDLE: accepts a request when any `req_valid` is high.
  - HOLD: `bus_enable`=1, down-counter runs.
  - GAP: `bus_enable`=0, counter runs.
- Arbitration: round-robin. Search starts at `last+1` and wraps modulo NUM_REQ; the first valid requester wins.
  - `last` resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - `last` updates only on accept.
- `req_ready[w]` = (state==IDLE) & winner==w. All ready bits are 0 outside IDLE or when no request is valid.
- Handshake: a transfer occurs on an edge where `req_valid[i] & req_ready[i]`.
  - Requesters hold valid and data until accepted.
  - If valid drops before accept, the arbiter re-evaluates each cycle. No lock-in.
- On accept at edge E:
  - `unsync_bus` ← `req_data[w]`, `bus_enable` ← 1, `grant_id` ← w, `last` ← w.
  - counter ← HOLD_CYCLES-1, state ← HOLD.
- HOLD: decrement each edge. At count 0: state ← GAP, counter ← GAP_CYCLES-1, `bus_enable` ← 0.
- GAP: decrement each edge. At count 0: state ← IDLE.
- `unsync_bus` holds its value through HOLD, GAP and IDLE until the next accept.
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES))+1.
- No data FIFO: exactly one word is in flight.

## Timing
- Reset values: `unsync_bus`=0, `bus_enable`=0, `grant_id`=0, `busy`=0, `req_ready`=0 (the combinational ready is also 0 while `RST` is low), state=IDLE, counter=0, `last`=NUM_REQ-1.
- Accept at edge E:
  - `bus_enable` is high from E to E+HOLD_CYCLES.
  - `bus_enable` is low during GAP from E+HOLD_CYCLES to E+HOLD_CYCLES+GAP_CYCLES.
  - The block is back in IDLE after E+HOLD_CYCLES+GAP_CYCLES.
  - Earliest next accept is at edge E+HOLD_CYCLES+GAP_CYCLES+1, giving a minimum word spacing of 11 cycles at defaults.
- `busy` is high from E+1 through the last GAP cycle.
- Simultaneous valids: exactly one ready. Losers keep valid and are served in round-robin order.
- Reset mid-operation: all outputs clear asynchronously and `bus_enable` drops immediately. The in-flight word is abandoned; no retry.
- A requester re-asserting immediately after its own accept is served again only if no other requester is valid at the next IDLE.

## Test plan
- Single request, defaults: req 0 valid with 0xA5 at edge E.
  - `req_ready[0]`=1 for one cycle; `unsync_bus`=0xA5, `grant_id`=0.
  - `bus_enable` high for 6 cycles, then low for 4; `busy` low again after E+10.
- Simultaneous: all four requesters valid with data 0x10/0x21/0x32/0x43, held until accepted.
  - Accept order is 0,1,2,3, each spaced 11 cycles.
  - `unsync_bus` takes each word during its HOLD; exactly one `req_ready` bit high per accept.
- Fairness/wrap: requesters 2 and 3 valid continuously after one accept of requester 3.
  - Order is 2,3,2,3…; the pointer wraps 3→0→…→2 correctly.
- Back-to-back same requester: req 1 alone, re-asserts immediately after each accept.
  - Accepts at E, E+11, E+22; `bus_enable` gap is exactly 4 low cycles each time.
- Reset mid-HOLD: assert `RST` low 3 cycles after an accept.
  - `bus_enable`, `unsync_bus`, `busy` go to 0 without a clock edge.
  - After release, a pending req 0 is accepted on the first IDLE edge.
- Withdrawn request: req 2 valid for one cycle while busy, then dropped before IDLE.
  - No accept occurs; `req_ready` stays 0 and the FSM remains IDLE.

Source files
------------

// File: rtl/data_sync_tx_arbiter.sv
// data_sync_tx_arbiter
//   Source-domain scheduler in front of a multi-flop data synchronizer.
//   Several requesters share one synchronizer channel. Words are accepted
//   one at a time via valid/ready with round-robin arbitration. Each word is
//   held on unsync_bus with bus_enable high for HOLD_CYCLES cycles. A low gap
//   of GAP_CYCLES cycles follows, so the destination edge detector sees
//   exactly one clean rising edge per word.
//
// Ports
//   CLK         source clock, all state on the rising edge
//   RST         asynchronous active-low reset
//   req_valid   per-requester valid
//   req_data    requester i word at [i*BUS_WIDTH +: BUS_WIDTH]
//   req_ready   one-hot accept strobe (combinational, IDLE only)
//   unsync_bus  registered word presented to the synchronizer
//   bus_enable  registered enable level presented to the synchronizer
//   grant_id    index of the most recently accepted requester
//   busy        high whenever a word is in HOLD or GAP
module data_sync_tx_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [BUS_WIDTH-1:0]           unsync_bus,
  output logic                           bus_enable,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      winner;
  logic                 win_valid;
  logic [BUS_WIDTH-1:0] win_data;
  logic                 accept;
  logic                 cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Round-robin search starting one past the last winner. Offsets are walked
  // from farthest to nearest so the nearest valid requester is written last
  // and therefore wins.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a signal unassigned would infer a latch.
    winner    = '0;
    win_valid = 1'b0;
    win_data  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      int idx;
      idx = (int'(last_q) + off) % NUM_REQ;
      if (req_valid[ID_W'(idx)]) begin
        winner    = ID_W'(idx);
        win_valid = 1'b1;
        win_data  = BUS_WIDTH'(req_data >> (idx * BUS_WIDTH));
      end
    end
  end

  // Gated by RST so ready is guaranteed low while reset is held.
  assign accept = RST && (state_q == S_IDLE) && win_valid;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)   state_d = S_HOLD;
      S_HOLD: if (cnt_zero) state_d = S_GAP;
      S_GAP:  if (cnt_zero) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
  end

  // Datapath: captured word, enable level, grant pointer and phase counter.
  // The counter is loaded with N-1 so each phase lasts exactly N cycles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      grant_id   <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            unsync_bus <= win_data;
            bus_enable <= 1'b1;
            grant_id   <= winner;
            last_q     <= winner;
            cnt_q      <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            bus_enable <= 1'b0;
            cnt_q      <= CNT_W'(GAP_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule
